// File: rtl/sync_fifo_flags_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags_if
// Handshake/data bundle for the single-clock FIFO. Signal names match the
// dual-clock FIFO so either block can sit behind the same integration wiring.
//   master : producer/consumer side (drives winc/wdata/rinc, observes status)
//   slave  : FIFO side (consumes requests, drives rdata and all status flags)
// Signals:
//   winc, wdata            write request and data
//   rinc                   read request (pop of the head word in FWFT mode)
//   rdata                  read data
//   wfull, rempty          full / empty
//   walmost_full           count >= AFULL_TH
//   ralmost_empty          count <= AEMPTY_TH
//   count                  occupancy, 0..2^ASIZE
//   overflow, underflow    sticky error flags
// -----------------------------------------------------------------------------
interface sync_fifo_flags_if #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
);
  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             wfull;
  logic             rempty;
  logic             walmost_full;
  logic             ralmost_empty;
  logic [ASIZE:0]   count;
  logic             overflow;
  logic             underflow;

  modport master (
    output winc, wdata, rinc,
    input  rdata, wfull, rempty, walmost_full, ralmost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc,
    output rdata, wfull, rempty, walmost_full, ralmost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count, sticky overflow/underflow flags and a selectable read mode
// (registered read data, or first-word-fall-through).
// Ports:
//   clk  : single clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : sync_fifo_flags_if.slave (requests in, data and status out)
// -----------------------------------------------------------------------------
module sync_fifo_flags #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_flags_if.slave bus
);

  localparam int             DEPTH    = 1 << ASIZE;
  localparam logic [ASIZE:0] FULL_CNT = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AF_CNT   = (ASIZE+1)'(AFULL_TH);
  localparam logic [ASIZE:0] AE_CNT   = (ASIZE+1)'(AEMPTY_TH);
  localparam logic [ASIZE:0] ONE      = {{ASIZE{1'b0}}, 1'b1};

  // Threshold sanity, evaluated at elaboration.
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("sync_fifo_flags: AFULL_TH out of range 1..2^ASIZE");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_flags: AEMPTY_TH out of range 0..2^ASIZE-1");
  end

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr;
  logic [ASIZE:0]   rptr;
  logic [ASIZE:0]   cnt;
  logic             ovf_q;
  logic             udf_q;
  logic             wfull;
  logic             rempty;
  logic             wr_en;
  logic             rd_en;

  // Flags decode the count register, so they are glitch-free and reflect an
  // accepted operation from the very edge that accepts it.
  assign wfull  = (cnt == FULL_CNT);
  assign rempty = (cnt == '0);

  // Accept decisions use state at the start of the cycle; a write into an
  // empty FIFO is never visible to a same-cycle read.
  assign wr_en = bus.winc && !wfull;
  assign rd_en = bus.rinc && !rempty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + ONE;
      if (rd_en) rptr <= rptr + ONE;
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + ONE;
        2'b01:   cnt <= cnt - ONE;
        default: cnt <= cnt;
      endcase
      if (bus.winc && wfull)  ovf_q <= 1'b1;
      if (bus.rinc && rempty) udf_q <= 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; only pointers and
  // count define which entries are valid, and a reset would prevent RAM
  // inference. Reset still blocks the write in its cycle.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wptr[ASIZE-1:0]] <= bus.wdata;
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented combinationally; valid whenever not empty.
    assign bus.rdata = mem[rptr[ASIZE-1:0]];
  end else begin : g_reg
    logic [DSIZE-1:0] rdata_q;
    always_ff @(posedge clk) begin
      if (rst)        rdata_q <= '0;
      else if (rd_en) rdata_q <= mem[rptr[ASIZE-1:0]];
    end
    assign bus.rdata = rdata_q;
  end

  assign bus.wfull         = wfull;
  assign bus.rempty        = rempty;
  assign bus.walmost_full  = (cnt >= AF_CNT);
  assign bus.ralmost_empty = (cnt <= AE_CNT);
  assign bus.count         = cnt;
  assign bus.overflow      = ovf_q;
  assign bus.underflow     = udf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_flags
// Drives three FIFO instances from one shared request stream:
//   d0 : defaults (registered read, AFULL_TH=12, AEMPTY_TH=2)
//   d1 : FWFT=1, default thresholds
//   d2 : registered read, AFULL_TH=4, AEMPTY_TH=0
// Every cycle all three are compared against a queue-based reference model.
// A vector table covers reset, fill/wrap and simultaneous operations on d0;
// hand-written sequences cover FWFT, thresholds and mid-traffic reset;
// randomized traffic finishes the run.
// -----------------------------------------------------------------------------
module tb_sync_fifo_flags;

  logic       clk;
  logic       rst;
  logic       winc;
  logic       rinc;
  logic [7:0] wdata;

  int n_total;
  int n_bad;

  sync_fifo_flags_if #(.DSIZE(8), .ASIZE(4)) if0 ();
  sync_fifo_flags_if #(.DSIZE(8), .ASIZE(4)) if1 ();
  sync_fifo_flags_if #(.DSIZE(8), .ASIZE(4)) if2 ();

  assign if0.winc = winc;  assign if0.rinc = rinc;  assign if0.wdata = wdata;
  assign if1.winc = winc;  assign if1.rinc = rinc;  assign if1.wdata = wdata;
  assign if2.winc = winc;  assign if2.rinc = rinc;  assign if2.wdata = wdata;

  sync_fifo_flags #(.DSIZE(8), .ASIZE(4), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(0))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  sync_fifo_flags #(.DSIZE(8), .ASIZE(4), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  sync_fifo_flags #(.DSIZE(8), .ASIZE(4), .AFULL_TH(4), .AEMPTY_TH(0), .FWFT(0))
    dut2 (.clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] mq[$];
  logic       m_ovf;
  logic       m_udf;
  logic [7:0] m_rreg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_step();
    if (rst) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_rreg = 8'h00;
    end else begin
      bit full  = (mq.size() == 16);
      bit empty = (mq.size() == 0);
      if (winc && full)  m_ovf = 1'b1;
      if (rinc && empty) m_udf = 1'b1;
      if (rinc && !empty) m_rreg = mq.pop_front();
      if (winc && !full)  mq.push_back(wdata);
    end
  endtask

  task automatic check_dut(input string tag, input int af_th, input int ae_th,
                           input logic [4:0] cnt, input logic wf, input logic re,
                           input logic af, input logic ae, input logic ov, input logic un);
    int n = mq.size();
    check({tag, ".count"},         32'(cnt), 32'(n));
    check({tag, ".wfull"},         32'(wf),  32'(n == 16));
    check({tag, ".rempty"},        32'(re),  32'(n == 0));
    check({tag, ".walmost_full"},  32'(af),  32'(n >= af_th));
    check({tag, ".ralmost_empty"}, 32'(ae),  32'(n <= ae_th));
    check({tag, ".overflow"},      32'(ov),  32'(m_ovf));
    check({tag, ".underflow"},     32'(un),  32'(m_udf));
  endtask

  task automatic compare_all();
    check_dut("d0", 12, 2, if0.count, if0.wfull, if0.rempty, if0.walmost_full,
              if0.ralmost_empty, if0.overflow, if0.underflow);
    check_dut("d1", 12, 2, if1.count, if1.wfull, if1.rempty, if1.walmost_full,
              if1.ralmost_empty, if1.overflow, if1.underflow);
    check_dut("d2", 4, 0, if2.count, if2.wfull, if2.rempty, if2.walmost_full,
              if2.ralmost_empty, if2.overflow, if2.underflow);
    check("d0.rdata", 32'(if0.rdata), 32'(m_rreg));
    check("d2.rdata", 32'(if2.rdata), 32'(m_rreg));
    if (mq.size() > 0) check("d1.rdata_head", 32'(if1.rdata), 32'(mq[0]));
  endtask

  // One clock: model sees the applied inputs, DUTs take the edge, outputs
  // are sampled 1 ns later.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // ---------------- vector table for d0 ----------------
  typedef struct {
    logic       rst;
    logic       winc;
    logic       rinc;
    logic [7:0] wdata;
    int         cnt;
    logic       ovf;
    logic       udf;
    logic       chk_rd;
    logic [7:0] rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic w, input logic rd, input logic [7:0] d,
                              input int c, input logic o, input logic u,
                              input logic cr, input logic [7:0] q);
    vec_t v;
    v.rst = r; v.winc = w; v.rinc = rd; v.wdata = d; v.cnt = c;
    v.ovf = o; v.udf = u; v.chk_rd = cr; v.rdata = q;
    vecs.push_back(v);
  endfunction

  initial begin
    rst = 1'b1; winc = 1'b0; rinc = 1'b0; wdata = 8'h00;
    n_total = 0; n_bad = 0;
    m_ovf = 1'b0; m_udf = 1'b0; m_rreg = 8'h00;

    // Reset defaults (two cycles of rst).
    add(1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h00);
    add(1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h00);
    // Fill/overflow/drain, then a second pass across the pointer wrap.
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 16; i++) add(0, 1, 0, 8'(16 * p + i), i + 1, (p == 1), 0, 0, 8'h00);
      if (p == 0) add(0, 1, 0, 8'hAA, 16, 1, 0, 0, 8'h00);
      for (int i = 0; i < 16; i++) add(0, 0, 1, 8'h00, 15 - i, 1, 0, 1, 8'(16 * p + i));
    end
    // Simultaneous read/write: mid-level, at full, at empty.
    add(1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 5; i++)  add(0, 1, 0, 8'(8'h20 + i), i + 1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 10; i++) add(0, 1, 1, 8'(8'h25 + i), 5, 0, 0, 1, 8'(8'h20 + i));
    for (int i = 0; i < 11; i++) add(0, 1, 0, 8'(8'h2F + i), 6 + i, 0, 0, 0, 8'h00);
    add(0, 1, 1, 8'hBB, 15, 1, 0, 1, 8'h2A);
    for (int i = 0; i < 15; i++) add(0, 0, 1, 8'h00, 14 - i, 1, 0, 1, 8'(8'h2B + i));
    add(0, 1, 1, 8'hCC, 1, 1, 1, 1, 8'h39);
    add(0, 0, 1, 8'h00, 0, 1, 1, 1, 8'hCC);

    foreach (vecs[k]) begin
      rst = vecs[k].rst; winc = vecs[k].winc; rinc = vecs[k].rinc; wdata = vecs[k].wdata;
      tick();
      check($sformatf("vec%0d.count", k),  32'(if0.count),         32'(vecs[k].cnt));
      check($sformatf("vec%0d.wfull", k),  32'(if0.wfull),         32'(vecs[k].cnt == 16));
      check($sformatf("vec%0d.rempty", k), 32'(if0.rempty),        32'(vecs[k].cnt == 0));
      check($sformatf("vec%0d.afull", k),  32'(if0.walmost_full),  32'(vecs[k].cnt >= 12));
      check($sformatf("vec%0d.aempty", k), 32'(if0.ralmost_empty), 32'(vecs[k].cnt <= 2));
      check($sformatf("vec%0d.ovf", k),    32'(if0.overflow),      32'(vecs[k].ovf));
      check($sformatf("vec%0d.udf", k),    32'(if0.underflow),     32'(vecs[k].udf));
      if (vecs[k].chk_rd) check($sformatf("vec%0d.rdata", k), 32'(if0.rdata), 32'(vecs[k].rdata));
    end
    rst = 1'b0; winc = 1'b0; rinc = 1'b0;

    // FWFT: first word visible the cycle after its write, no rinc needed.
    rst = 1'b1; tick(); rst = 1'b0;
    winc = 1'b1; wdata = 8'h5A; tick(); winc = 1'b0;
    check("fwft.rempty_after_write", 32'(if1.rempty), 32'(1'b0));
    check("fwft.rdata_fallthrough",  32'(if1.rdata),  32'(8'h5A));
    rinc = 1'b1; tick(); rinc = 1'b0;
    check("fwft.rempty_after_pop", 32'(if1.rempty), 32'(1'b1));
    check("reg.rdata_after_pop",   32'(if0.rdata),  32'(8'h5A));

    // Thresholds AFULL_TH=4, AEMPTY_TH=0 on d2.
    rst = 1'b1; tick(); rst = 1'b0;
    check("th.aempty_at_reset", 32'(if2.ralmost_empty), 32'(1'b1));
    for (int j = 1; j <= 4; j++) begin
      winc = 1'b1; wdata = 8'(j); tick();
      check($sformatf("th.aempty_w%0d", j), 32'(if2.ralmost_empty), 32'(1'b0));
      check($sformatf("th.afull_w%0d", j),  32'(if2.walmost_full),  32'(j == 4));
    end
    winc = 1'b0; rinc = 1'b1; tick(); rinc = 1'b0;
    check("th.afull_after_read", 32'(if2.walmost_full), 32'(1'b0));
    check("th.count_after_read", 32'(if2.count),        32'(3));

    // Reset in the middle of traffic at count=9 with overflow set.
    rst = 1'b1; tick(); rst = 1'b0;
    winc = 1'b1;
    for (int j = 0; j < 17; j++) begin wdata = 8'(8'h40 + j); tick(); end
    winc = 1'b0; rinc = 1'b1;
    for (int j = 0; j < 7; j++) tick();
    rinc = 1'b0;
    check("mid.count_before", 32'(if0.count),    32'(9));
    check("mid.ovf_before",   32'(if0.overflow), 32'(1'b1));
    rst = 1'b1; winc = 1'b1; rinc = 1'b1; wdata = 8'hEE; tick();
    rst = 1'b0; winc = 1'b0; rinc = 1'b0;
    check("mid.count_after",  32'(if0.count),    32'(0));
    check("mid.rempty_after", 32'(if0.rempty),   32'(1'b1));
    check("mid.ovf_after",    32'(if0.overflow), 32'(1'b0));
    winc = 1'b1; wdata = 8'h77; tick(); winc = 1'b0;
    check("mid.fwft_new_head", 32'(if1.rdata), 32'(8'h77));
    rinc = 1'b1; tick(); rinc = 1'b0;
    check("mid.rdata_new_only", 32'(if0.rdata),  32'(8'h77));
    check("mid.rempty_drained", 32'(if0.rempty), 32'(1'b1));

    // Randomized traffic with phases biased toward full, empty and balanced.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int ph = (cyc / 300) % 3;
      int pw = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
      int pr = (ph == 0) ? 25 : (ph == 1) ? 80 : 50;
      rst   = ($urandom_range(0, 249) == 0);
      winc  = ($urandom_range(0, 99) < pw);
      rinc  = ($urandom_range(0, 99) < pr);
      wdata = 8'($urandom);
      tick();
    end
    rst = 1'b0; winc = 1'b0; rinc = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
